uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Read-side consumer of the bridge's TX byte FIFO. Pops one byte at a time and serializes it onto the UART TXD line.
- Frame format is 8N1 by default: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits between the TX FIFO (8-bit sync_fifo, registered read) and the UART pad. Honours optional CTS flow control from the host.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- STOP_BITS, 1, number of stop bits. Legal values 1 or 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- fifo_empty  input  1  TX FIFO empty flag
- fifo_rd_data  input  8  TX FIFO read data; valid the cycle after fifo_rd_en
- fifo_rd_en  output  1  single-cycle pop strobe to the TX FIFO
- cts_n  input  1  clear-to-send, active low, already synchronized; high blocks new frames
- txd  output  1  UART serial out, idle high (mark)
- busy  output  1  high while a frame is being fetched or shifted
- frame_done  output  1  one-cycle pulse on the last clk of the final stop bit

Behaviour:
- Reset (async assert) values: txd=1, busy=0, fifo_rd_en=0, frame_done=0, state=IDLE, all counters=0.
- Reset mid-frame aborts immediately: txd returns to 1 and the in-flight byte is lost. The FIFO has already been popped, so there is no re-read.
- States and transitions:
  - IDLE: go to FETCH when fifo_empty=0 and cts_n=0.
  - FETCH: fifo_rd_en=1 for exactly this cycle; go to LOAD.
  - LOAD: capture fifo_rd_data into the shift register; clear baud_cnt and bit_cnt; go to START.
  - START: txd=0 for CLKS_PER_BIT cycles; go to DATA.
  - DATA: txd=shift[0]; shift right every CLKS_PER_BIT cycles; after 8 bits go to PARITY (feature on) or STOP.
  - PARITY: txd = parity bit for CLKS_PER_BIT cycles; go to STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done pulses on the final cycle; go to IDLE.
- txd is driven from a register. There is no combinational path from any input to txd.
- busy=1 in every state except IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps.
  - The bit boundary is at count CLKS_PER_BIT-1.
  - The bit counter is 3 bits and wraps 7->0 on DATA exit.
- Timing:
  - Frame length is exactly (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and P=0 otherwise.
  - First start-bit cycle is 2 clk after IDLE sees a non-empty FIFO (FETCH, LOAD).
- Back-to-back frames: after STOP, IDLE re-evaluates on the next cycle. The inter-frame mark gap is therefore exactly 3 clk (IDLE, FETCH, LOAD).
- cts_n is sampled only in IDLE. Deasserting it mid-frame does not truncate the frame; the current frame completes.
- fifo_rd_en is never asserted when fifo_empty=1 in the same cycle. The FIFO is never underflowed.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit, quasi-static). The PARITY state is inserted.
  - Parity bit = ^data when parity_odd=0 (even parity), ~^data when parity_odd=1 (odd parity).
  - Frame grows by CLKS_PER_BIT cycles.
- Undefined: no parity_odd port, no PARITY state, and frame is 8N1/8N2.

Test Plan:
- Single byte: CLKS_PER_BIT=4, STOP_BITS=1, push 0xA5 -> one fifo_rd_en pulse; txd low 4 clk, then 1,0,1,0,0,1,0,1 at 4 clk each, then high 4 clk; busy high 42 clk; frame_done pulses once at cycle 42.
- Back-to-back: push 0x00 then 0xFF -> two frames of 40 clk each separated by exactly 3 clk of txd=1; exactly 2 pops; FIFO empty afterwards; busy low in the gap cycle IDLE only.
- Flow control: cts_n=1 with 3 bytes queued -> no fifo_rd_en, txd=1 for 100 clk. Release cts_n -> frames start. Raise cts_n mid-frame 2 -> frame 2 completes and frame 3 is withheld.
- Reset mid-frame: assert rst during DATA bit 4 of 0x3C -> txd=1 and busy=0 asynchronously. After release with FIFO empty -> txd stays 1 and no pop.
- STOP_BITS=2, CLKS_PER_BIT=3: byte 0x80 -> stop high for 6 clk; total frame 33 clk; txd bit 7 = 1.
- UART_TX_PARITY_EN: 0x07 with parity_odd=0 -> parity bit 1; with parity_odd=1 -> parity bit 0; frame 44 clk at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Read-side consumer of the TX byte FIFO. Pops one byte at a time from a
// registered-read FIFO and shifts it out on txd as a UART frame:
// start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// New frames are started only while cts_n is low; a frame in flight always
// completes.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> parity_odd input and a parity bit after the data bits
//                (even parity when parity_odd=0, odd when parity_odd=1)
//   undefined -> 8N1 / 8N2 frames, no parity_odd port
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   fifo_empty    TX FIFO empty flag
//   fifo_rd_data  TX FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    single-cycle pop strobe to the TX FIFO
//   cts_n         clear-to-send (active low, already synchronized)
//   parity_odd    parity sense, quasi-static (UART_TX_PARITY_EN only)
//   txd           UART serial output, idle high
//   busy          high in every state except IDLE
//   frame_done    one-cycle pulse on the last clk of the final stop bit
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | line at mark, waiting for a byte and cts_n low
//   FETCH   | pop strobe to the FIFO for one cycle
//   LOAD    | FIFO data valid, capture into the shift register
//   START   | start bit (txd low) for one bit time
//   DATA    | 8 data bits, LSB first
//   PARITY  | parity bit (only with UART_TX_PARITY_EN)
//   STOP    | stop bit(s), txd high; frame_done on the final cycle
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  input  logic       cts_n,
`ifdef UART_TX_PARITY_EN
  input  logic       parity_odd,
`endif
  output logic       txd,
  output logic       busy,
  output logic       frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [2:0]        bit_q,   bit_d;
  logic              txd_q,   txd_d;
  logic              baud_last;
`ifdef UART_TX_PARITY_EN
  logic              par_q,   par_d;
`endif

  assign baud_last = (baud_q == BAUD_LAST);
  assign txd       = txd_q;
  assign busy      = (state_q != S_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. txd is registered from the next-state decode so the
  // pin changes on the same edge the state does, with no path from inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and outputs
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    txd_d      = txd_q;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty && !cts_n) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        // IDLE already saw a byte and nothing else pops this FIFO, so the
        // empty gate is only a guard against underflow.
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = S_LOAD;
        end else begin
          state_d    = S_IDLE;
        end
      end

      S_LOAD: begin
        shift_d = fifo_rd_data;
        baud_d  = '0;
        bit_d   = '0;
        txd_d   = 1'b0;
        state_d = S_START;
`ifdef UART_TX_PARITY_EN
        // Latched now because the shift register is consumed by DATA.
        par_d   = (^fifo_rd_data) ^ parity_odd;
`endif
      end

      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          txd_d   = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = S_PARITY;
`else
            txd_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          txd_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        // bit_cnt re-used to count stop bits; it is 0 on entry.
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d      = '0;
            frame_done = 1'b1;
            txd_d      = 1'b1;
            state_d    = S_IDLE;
          end else begin
            bit_d      = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] fifo_empty;
  logic [1:0] fifo_rd_en;
  logic [1:0] cts_n = 2'b00;
  logic [1:0] txd;
  logic [1:0] busy;
  logic [1:0] frame_done;
  logic [7:0] rd_data [2];
  logic       parity_odd = 1'b0;

  // Bench FIFO storage (registered read), shared by the model's byte stream
  logic [7:0] fmem [2][64];
  int         fhead [2] = '{0, 0};
  int         ftail [2] = '{0, 0};

  int checks = 0;
  int errors = 0;
  int pop_cnt  [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};

  // Model: a transaction is FETCH(0), LOAD(1), then frame cycles from 2
  bit         m_act  [2] = '{0, 0};
  int         m_t    [2] = '{0, 0};
  int         m_head [2] = '{0, 0};
  logic [7:0] m_byte [2] = '{8'h00, 8'h00};

  always #5 clk = ~clk;

  assign fifo_empty[0] = (fhead[0] == ftail[0]);
  assign fifo_empty[1] = (fhead[1] == ftail[1]);

  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty[0]),
    .fifo_rd_data (rd_data[0]),
    .fifo_rd_en   (fifo_rd_en[0]),
    .cts_n        (cts_n[0]),
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .txd          (txd[0]),
    .busy         (busy[0]),
    .frame_done   (frame_done[0])
  );

  uart_tx_serializer #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty[1]),
    .fifo_rd_data (rd_data[1]),
    .fifo_rd_en   (fifo_rd_en[1]),
    .cts_n        (cts_n[1]),
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .txd          (txd[1]),
    .busy         (busy[1]),
    .frame_done   (frame_done[1])
  );

  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int stopb(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int flen(input int i);
    return (1 + 8 + PAR + stopb(i)) * cpb(i);
  endfunction

  // Bit k of a frame: 0 start, 1..8 data LSB first, 9 parity (if on), rest stop
  function automatic logic exp_bit(input logic [7:0] b, input int k, input logic po);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return (^b) ^ po;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fmem[i][ftail[i] % 64] = b;
    ftail[i] = ftail[i] + 1;
  endtask

  // Registered-read FIFO behaviour
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_rd_en[i] && (fhead[i] != ftail[i])) begin
        rd_data[i] <= fmem[i][fhead[i] % 64];
        fhead[i]   <= fhead[i] + 1;
      end
    end
  end

  // Model and per-cycle compare
  always @(negedge clk) begin
    logic e_txd, e_busy, e_rd, e_done;
    for (int i = 0; i < 2; i++) begin
      pop_cnt[i]  = pop_cnt[i]  + int'(fifo_rd_en[i]);
      done_cnt[i] = done_cnt[i] + int'(frame_done[i]);
      if (rst) begin
        m_act[i] = 1'b0;
        m_t[i]   = 0;
      end
      if (m_act[i]) begin
        e_busy = 1'b1;
        e_rd   = (m_t[i] == 0);
        e_txd  = (m_t[i] < 2) ? 1'b1
                 : exp_bit(m_byte[i], (m_t[i] - 2) / cpb(i), parity_odd);
        e_done = (m_t[i] == flen(i) + 1);
      end else begin
        e_busy = 1'b0;
        e_rd   = 1'b0;
        e_txd  = 1'b1;
        e_done = 1'b0;
      end
      chk($sformatf("model_txd%0d", i),   txd[i],        e_txd);
      chk($sformatf("model_busy%0d", i),  busy[i],       e_busy);
      chk($sformatf("model_rden%0d", i),  fifo_rd_en[i], e_rd);
      chk($sformatf("model_done%0d", i),  frame_done[i], e_done);
      if (!rst) begin
        if (m_act[i]) begin
          m_t[i] = m_t[i] + 1;
          if (m_t[i] == flen(i) + 2) m_act[i] = 1'b0;
        end else if ((ftail[i] - m_head[i]) > 0 && !cts_n[i]) begin
          m_act[i]  = 1'b1;
          m_t[i]    = 0;
          m_byte[i] = fmem[i][m_head[i] % 64];
          m_head[i] = m_head[i] + 1;
        end
      end
    end
  end

  // Observe one frame: busy cycle count, frame_done position, mid-bit samples
  // packed as bits[k], and the trailing run of txd high at the frame's end.
  task automatic measure(input int i, output int nbusy, output int ndone,
                         output int dpos, output int bits, output int hirun);
    int c;
    int f;
    c = cpb(i);
    nbusy = 0; ndone = 0; dpos = -1; bits = 0; hirun = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (busy[i]) begin
        nbusy++;
        if (frame_done[i]) begin
          ndone++;
          dpos = nbusy;
        end
        f = nbusy - 3;
        if (f >= 0) begin
          if (f % c == c / 2) bits = bits | (int'(txd[i]) << (f / c));
          if (txd[i]) hirun++;
          else hirun = 0;
        end
      end else if (nbusy > 0) begin
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, dp, bits, hr;
    int p0, dc0, p1;
    int d1, d2, gap, lowb, ntx0, nrd;
    bit s2, got;

    // Reset state, asserted asynchronously before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_txd0", txd[0], 1);
    chk("rst_busy0", busy[0], 0);
    chk("rst_rden0", fifo_rd_en[0], 0);
    chk("rst_done0", frame_done[0], 0);
    chk("rst_txd1", txd[1], 1);
    chk("rst_busy1", busy[1], 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single byte 0xA5
    @(posedge clk); #1;
    p0 = pop_cnt[0];
    push(0, 8'hA5);
    measure(0, nb, nd, dp, bits, hr);
    chk("a5_busy_len", nb, 42 + 4 * PAR);
    chk("a5_done_cnt", nd, 1);
    chk("a5_done_pos", dp, 42 + 4 * PAR);
    chk("a5_bits", bits, (PAR == 1) ? 32'h54A : 32'h34A);
    @(posedge clk); #1;
    chk("a5_pops", pop_cnt[0] - p0, 1);

    // Back-to-back 0x00, 0xFF
    p0 = pop_cnt[0]; dc0 = done_cnt[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    d1 = -1; d2 = -1; gap = 0; lowb = 0; s2 = 1'b0;
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      if (d1 >= 0 && d2 < 0) begin
        if (!busy[0]) lowb++;
        if (!s2) begin
          if (txd[0]) gap++;
          else s2 = 1'b1;
        end
      end
      if (frame_done[0]) begin
        if (d1 < 0) d1 = t;
        else if (d2 < 0) d2 = t;
      end
    end
    @(posedge clk); #1;
    chk("b2b_pops", pop_cnt[0] - p0, 2);
    chk("b2b_done_cnt", done_cnt[0] - dc0, 2);
    chk("b2b_spacing", d2 - d1, 43 + 4 * PAR);
    chk("b2b_gap_mark", gap, 3);
    chk("b2b_busy_low", lowb, 1);
    chk("b2b_fifo_empty", fifo_empty[0], 1);

    // Flow control
    cts_n[0] = 1'b1;
    p0 = pop_cnt[0];
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    ntx0 = 0; nrd = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!txd[0]) ntx0++;
      if (fifo_rd_en[0]) nrd++;
    end
    chk("cts_hold_pops", nrd, 0);
    chk("cts_hold_txd_low", ntx0, 0);
    @(posedge clk); #1;
    cts_n[0] = 1'b0;
    dc0 = done_cnt[0];
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (pop_cnt[0] - p0 >= 2) begin
        got = 1'b1;
        break;
      end
    end
    chk("cts_second_pop", got, 1);
    repeat (16) @(posedge clk);
    #1 cts_n[0] = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    chk("cts_mid_pops", pop_cnt[0] - p0, 2);
    chk("cts_mid_done", done_cnt[0] - dc0, 2);
    chk("cts_mid_left", ftail[0] - fhead[0], 1);
    chk("cts_mid_idle", busy[0], 0);
    cts_n[0] = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("cts_drain_pops", pop_cnt[0] - p0, 3);
    chk("cts_drain_empty", fifo_empty[0], 1);

    // Reset during DATA bit 4 of 0x3C
    p0 = pop_cnt[0]; dc0 = done_cnt[0];
    push(0, 8'h3C);
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (fifo_rd_en[0]) begin
        got = 1'b1;
        break;
      end
    end
    chk("rstmid_fetch", got, 1);
    repeat (22) @(posedge clk);
    #1;
    chk("rstmid_pre_busy", busy[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_txd", txd[0], 1);
    chk("rstmid_busy", busy[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    p1 = pop_cnt[0];
    repeat (30) @(posedge clk);
    #1;
    chk("rstmid_no_pop", pop_cnt[0] - p1, 0);
    chk("rstmid_one_pop", pop_cnt[0] - p0, 1);
    chk("rstmid_no_done", done_cnt[0] - dc0, 0);
    chk("rstmid_idle_txd", txd[0], 1);

    // Two stop bits, 3 clk per bit, byte 0x80
    push(1, 8'h80);
    measure(1, nb, nd, dp, bits, hr);
    chk("stop2_busy_len", nb, 35 + 3 * PAR);
    chk("stop2_frame_len", dp - 2, 33 + 3 * PAR);
    chk("stop2_done_cnt", nd, 1);
    chk("stop2_bits", bits, (PAR == 1) ? 32'hF00 : 32'h700);
    chk("stop2_tail_high", hr, 9 + 3 * PAR);

`ifdef UART_TX_PARITY_EN
    // Parity on 0x07, even then odd
    @(posedge clk); #1;
    parity_odd = 1'b0;
    push(0, 8'h07);
    measure(0, nb, nd, dp, bits, hr);
    chk("par_even_len", nb, 46);
    chk("par_even_bits", bits, 32'h60E);
    @(posedge clk); #1;
    parity_odd = 1'b1;
    push(0, 8'h07);
    measure(0, nb, nd, dp, bits, hr);
    chk("par_odd_len", nb, 46);
    chk("par_odd_bits", bits, 32'h40E);
`endif

    repeat (5) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
